// File: rtl/ycbcr_capture_pkg.sv
// Shared definitions for the OV7670 YCbCr capture front end:
// frame-sync states, byte-order selectors and default frame geometry.
package ycbcr_capture_pkg;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_VS     = 2'd1,
        ST_ACTIVE = 2'd2
    } cap_state_t;

    localparam int   H_ACTIVE_DEF   = 640;
    localparam int   V_ACTIVE_DEF   = 480;
    localparam int   FRAME_SKIP_DEF = 2;

    localparam bit   ORDER_CB_FIRST = 1'b1;
    localparam bit   ORDER_CR_FIRST = 1'b0;

    localparam int   X_W    = 10;
    localparam int   Y_W    = 9;
    localparam int   SKIP_W = 4;

endpackage

// File: rtl/ycbcr_capture_sync_in.sv
// Camera input register stage: one flop on D/HREF/VSYNC, plus edge
// detection on the registered HREF and VSYNC.
module ycbcr_capture_sync_in (
    input  logic       PCLK,
    input  logic       rst_n,
    input  logic       VSYNC,
    input  logic       HREF,
    input  logic [7:0] D,
    output logic [7:0] d_r,
    output logic       href_r,
    output logic       vsync_r,
    output logic       href_fall,
    output logic       vsync_rise,
    output logic       vsync_fall
);

    logic href_d;
    logic vsync_d;

    always_ff @(posedge PCLK or negedge rst_n) begin
        if (!rst_n) begin
            d_r     <= '0;
            href_r  <= 1'b0;
            vsync_r <= 1'b0;
            href_d  <= 1'b0;
            vsync_d <= 1'b0;
        end else begin
            d_r     <= D;
            href_r  <= HREF;
            vsync_r <= VSYNC;
            href_d  <= href_r;
            vsync_d <= vsync_r;
        end
    end

    assign href_fall  = href_d & ~href_r;
    assign vsync_rise = vsync_r & ~vsync_d;
    assign vsync_fall = vsync_d & ~vsync_r;

endmodule

// File: rtl/ycbcr_capture.sv
// OV7670 YCbCr 4:2:2 deserialiser: byte stream to one pixel per e_pix strobe
// with x/y position, frame sync, settle-frame skipping and line checking.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_SYNC   | waiting for VSYNC high (after reset or a skipped frame)
// ST_VS     | in vertical blanking, waiting for VSYNC to fall
// ST_ACTIVE | capturing the frame until the next VSYNC rise
module ycbcr_capture
    import ycbcr_capture_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int FRAME_SKIP = FRAME_SKIP_DEF,
    parameter bit CB_FIRST   = ORDER_CB_FIRST
) (
    input  logic           PCLK,
    input  logic           rst_n,
    input  logic           VSYNC,
    input  logic           HREF,
    input  logic [7:0]     D,
    output logic           e_pix,
    output logic [7:0]     Y,
    output logic [7:0]     Cb,
    output logic [7:0]     Cr,
    output logic [X_W-1:0] x_pos,
    output logic [Y_W-1:0] y_pos,
    output logic           frame_start,
    output logic           frame_done,
    output logic           line_err
);

    localparam logic [X_W-1:0]    H_LIM    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]    V_LIM    = Y_W'(V_ACTIVE);
    localparam logic [SKIP_W-1:0] SKIP_LIM = SKIP_W'(FRAME_SKIP);

    logic [7:0] d_r;
    logic       href_r, vsync_r, href_fall, vsync_rise, vsync_fall;

    ycbcr_capture_sync_in u_sync_in (
        .PCLK       (PCLK),
        .rst_n      (rst_n),
        .VSYNC      (VSYNC),
        .HREF       (HREF),
        .D          (D),
        .d_r        (d_r),
        .href_r     (href_r),
        .vsync_r    (vsync_r),
        .href_fall  (href_fall),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall)
    );

    cap_state_t        state_q, state_d;
    logic              enter_active, skip_inc, done_d;
    logic [SKIP_W-1:0] skip_cnt;
    logic [1:0]        ph;
    logic [7:0]        c0, y0;
    logic [X_W-1:0]    x_cnt;
    logic [Y_W-1:0]    y_cnt;
    logic              in_frame, emit_ok;

    // pixel staged one cycle ahead of the output registers
    logic              req_v, req_fs;
    logic [7:0]        req_y, req_cb, req_cr;
    logic [X_W-1:0]    req_x;
    logic [Y_W-1:0]    req_yp;

    always_comb begin
        state_d      = state_q;
        enter_active = 1'b0;
        skip_inc     = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (vsync_r) state_d = ST_VS;
            end
            ST_VS: begin
                if (vsync_fall) begin
                    if (skip_cnt == SKIP_LIM) begin
                        state_d      = ST_ACTIVE;
                        enter_active = 1'b1;
                    end else begin
                        skip_inc = 1'b1;
                        state_d  = ST_SYNC;
                    end
                end
            end
            ST_ACTIVE: begin
                if (vsync_rise) begin
                    done_d  = 1'b1;
                    state_d = ST_VS;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge PCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SYNC;
            skip_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (skip_inc && skip_cnt != {SKIP_W{1'b1}})
                skip_cnt <= skip_cnt + 1'b1;
        end
    end

    // A VSYNC rise aborts the line in the same cycle it is seen.
    assign in_frame = (state_q == ST_ACTIVE) && !vsync_r && (y_cnt < V_LIM);
    assign emit_ok  = in_frame && href_r && ph[1] && (x_cnt < H_LIM);

    always_ff @(posedge PCLK or negedge rst_n) begin
        if (!rst_n) begin
            ph     <= '0;
            c0     <= '0;
            y0     <= '0;
            x_cnt  <= '0;
            y_cnt  <= '0;
            req_v  <= 1'b0;
            req_fs <= 1'b0;
            req_y  <= '0;
            req_cb <= '0;
            req_cr <= '0;
            req_x  <= '0;
            req_yp <= '0;
        end else begin
            ph <= (!href_r || vsync_r) ? 2'd0 : ph + 2'd1;

            if (href_r) begin
                case (ph)
                    2'd0: c0 <= d_r;
                    2'd1: y0 <= d_r;
                    2'd2: begin
                        req_y  <= y0;
                        req_cb <= CB_FIRST ? c0  : d_r;
                        req_cr <= CB_FIRST ? d_r : c0;
                    end
                    default: req_y <= d_r;
                endcase
            end

            req_v <= emit_ok;
            if (emit_ok) begin
                req_x  <= x_cnt;
                req_yp <= y_cnt;
                req_fs <= (x_cnt == '0) && (y_cnt == '0);
            end

            if (!href_r)
                x_cnt <= '0;
            else if (emit_ok)
                x_cnt <= x_cnt + 1'b1;

            if (enter_active)
                y_cnt <= '0;
            else if (state_q == ST_ACTIVE && href_fall && y_cnt < V_LIM)
                y_cnt <= y_cnt + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge rst_n) begin
        if (!rst_n) begin
            e_pix       <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            Y           <= '0;
            Cb          <= '0;
            Cr          <= '0;
            x_pos       <= '0;
            y_pos       <= '0;
        end else begin
            e_pix       <= req_v;
            frame_start <= req_v && req_fs;
            frame_done  <= done_d;
            if (req_v) begin
                Y     <= req_y;
                Cb    <= req_cb;
                Cr    <= req_cr;
                x_pos <= req_x;
                y_pos <= req_yp;
            end
            // partial 4-byte group at line end, or bytes past the last column
            if (enter_active)
                line_err <= 1'b0;
            else if (in_frame && ((href_fall && ph != 2'd0) || (href_r && x_cnt >= H_LIM)))
                line_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ycbcr_capture.sv
// Directed bench for ycbcr_capture: three instances share one camera stream
// (A: skip 0 Cb-first, B: skip 2, C: Cr-first), all with a 4x2 frame.
module tb_ycbcr_capture;

    typedef struct {
        int         cyc;
        logic [7:0] y, cb, cr;
        logic [9:0] x;
        logic [8:0] yp;
        logic       fs;
    } pix_t;

    logic       PCLK = 1'b0;
    logic       rst_n, VSYNC, HREF;
    logic [7:0] D;

    logic       e_a, fs_a, fdn_a, le_a, e_b, fs_b, fdn_b, le_b, e_c, fs_c, fdn_c, le_c;
    logic [7:0] y_a, cb_a, cr_a, y_b, cb_b, cr_b, y_c, cb_c, cr_c;
    logic [9:0] x_a, x_b, x_c;
    logic [8:0] yp_a, yp_b, yp_c;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   fd_a = 0, fd_b = 0, fd_c = 0;
    int   t_ph2 = 0;
    pix_t qa[$], qb[$], qc[$];

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc = cyc + 1;

    ycbcr_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .FRAME_SKIP(0), .CB_FIRST(1'b1)) dut_a (
        .PCLK(PCLK), .rst_n(rst_n), .VSYNC(VSYNC), .HREF(HREF), .D(D),
        .e_pix(e_a), .Y(y_a), .Cb(cb_a), .Cr(cr_a), .x_pos(x_a), .y_pos(yp_a),
        .frame_start(fs_a), .frame_done(fdn_a), .line_err(le_a));

    ycbcr_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .FRAME_SKIP(2), .CB_FIRST(1'b1)) dut_b (
        .PCLK(PCLK), .rst_n(rst_n), .VSYNC(VSYNC), .HREF(HREF), .D(D),
        .e_pix(e_b), .Y(y_b), .Cb(cb_b), .Cr(cr_b), .x_pos(x_b), .y_pos(yp_b),
        .frame_start(fs_b), .frame_done(fdn_b), .line_err(le_b));

    ycbcr_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .FRAME_SKIP(0), .CB_FIRST(1'b0)) dut_c (
        .PCLK(PCLK), .rst_n(rst_n), .VSYNC(VSYNC), .HREF(HREF), .D(D),
        .e_pix(e_c), .Y(y_c), .Cb(cb_c), .Cr(cr_c), .x_pos(x_c), .y_pos(yp_c),
        .frame_start(fs_c), .frame_done(fdn_c), .line_err(le_c));

    always @(negedge PCLK) begin
        if (e_a) qa.push_back('{cyc, y_a, cb_a, cr_a, x_a, yp_a, fs_a});
        if (e_b) qb.push_back('{cyc, y_b, cb_b, cr_b, x_b, yp_b, fs_b});
        if (e_c) qc.push_back('{cyc, y_c, cb_c, cr_c, x_c, yp_c, fs_c});
        if (fdn_a) fd_a = fd_a + 1;
        if (fdn_b) fd_b = fd_b + 1;
        if (fdn_c) fd_c = fd_c + 1;
    end

    function automatic logic [43:0] pk(input pix_t p);
        return {p.y, p.cb, p.cr, p.x, p.yp, p.fs};
    endfunction

    task automatic clear_logs();
        qa.delete(); qb.delete(); qc.delete();
        fd_a = 0; fd_b = 0; fd_c = 0;
    endtask

    // bytes are packed MSB-first: byte i = bytes[95-8*i -: 8]
    task automatic send_line(input logic [95:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge PCLK);
            HREF = 1'b1;
            D    = bytes[95-8*i -: 8];
            if (i == 2) t_ph2 = cyc + 1;
        end
        @(negedge PCLK);
        HREF = 1'b0;
        D    = 8'h00;
        repeat (6) @(negedge PCLK);
    endtask

    task automatic vsync_pulse();
        @(negedge PCLK);
        VSYNC = 1'b1;
        repeat (4) @(negedge PCLK);
        VSYNC = 1'b0;
        repeat (4) @(negedge PCLK);
    endtask

    task automatic test_reset();
        logic [46:0] got;
        rst_n = 1'b0; VSYNC = 1'b0; HREF = 1'b0; D = 8'h00;
        repeat (3) @(negedge PCLK);
        got = {e_a, y_a, cb_a, cr_a, x_a, yp_a, fs_a, fdn_a, le_a};
        checks++;
        if (got !== 47'd0) begin errors++; $display("FAIL reset_a got %h exp 0", got); end
        got = {e_c, y_c, cb_c, cr_c, x_c, yp_c, fs_c, fdn_c, le_c};
        checks++;
        if (got !== 47'd0) begin errors++; $display("FAIL reset_c got %h exp 0", got); end
        rst_n = 1'b1;
        repeat (2) @(negedge PCLK);
        got = {e_a, y_a, cb_a, cr_a, x_a, yp_a, fs_a, fdn_a, le_a};
        checks++;
        if (got !== 47'd0) begin errors++; $display("FAIL post_reset_a got %h exp 0", got); end
    endtask

    task automatic test_basic();
        int t0;
        clear_logs();
        vsync_pulse();
        send_line(96'h80109020_84309440_00000000, 8);
        t0 = t_ph2;
        send_line(96'h80109020_00000000_00000000, 4);
        vsync_pulse();
        checks++;
        if (qa.size() != 6) begin errors++; $display("FAIL basic_count got %0d exp 6", qa.size()); end
        checks++;
        if (pk(qa[0]) !== {8'h10, 8'h80, 8'h90, 10'd0, 9'd0, 1'b1})
            begin errors++; $display("FAIL basic_px0 got %h exp %h", pk(qa[0]), {8'h10, 8'h80, 8'h90, 10'd0, 9'd0, 1'b1}); end
        checks++;
        if (qa[0].cyc != t0 + 2) begin errors++; $display("FAIL basic_latency got %0d exp %0d", qa[0].cyc, t0 + 2); end
        checks++;
        if (pk(qa[1]) !== {8'h20, 8'h80, 8'h90, 10'd1, 9'd0, 1'b0} || qa[1].cyc != t0 + 3)
            begin errors++; $display("FAIL basic_px1 got %h@%0d exp %h@%0d", pk(qa[1]), qa[1].cyc, {8'h20, 8'h80, 8'h90, 10'd1, 9'd0, 1'b0}, t0 + 3); end
        checks++;
        if (pk(qa[3]) !== {8'h40, 8'h84, 8'h94, 10'd3, 9'd0, 1'b0})
            begin errors++; $display("FAIL basic_px3 got %h exp %h", pk(qa[3]), {8'h40, 8'h84, 8'h94, 10'd3, 9'd0, 1'b0}); end
        checks++;
        if (pk(qa[4]) !== {8'h10, 8'h80, 8'h90, 10'd0, 9'd1, 1'b0})
            begin errors++; $display("FAIL basic_line2 got %h exp %h", pk(qa[4]), {8'h10, 8'h80, 8'h90, 10'd0, 9'd1, 1'b0}); end
        checks++;
        if (fd_a != 1) begin errors++; $display("FAIL basic_frame_done got %0d exp 1", fd_a); end
        checks++;
        if (le_a !== 1'b0) begin errors++; $display("FAIL basic_line_err got %b exp 0", le_a); end
    endtask

    task automatic test_skip();
        @(negedge PCLK); rst_n = 1'b0;
        @(negedge PCLK); rst_n = 1'b1;
        clear_logs();
        for (int f = 1; f <= 3; f++) begin
            vsync_pulse();
            send_line(96'h80109020_84309440_00000000, 8);
            send_line(96'h80109020_00000000_00000000, 4);
            if (f == 2) begin
                checks++;
                if (qb.size() != 0 || fd_b != 0)
                    begin errors++; $display("FAIL skip_frames12 got pix=%0d done=%0d exp 0/0", qb.size(), fd_b); end
            end
        end
        vsync_pulse();
        checks++;
        if (qb.size() != 6 || fd_b != 1)
            begin errors++; $display("FAIL skip_frame3 got pix=%0d done=%0d exp 6/1", qb.size(), fd_b); end
        checks++;
        if (pk(qb[0]) !== {8'h10, 8'h80, 8'h90, 10'd0, 9'd0, 1'b1})
            begin errors++; $display("FAIL skip_px0 got %h exp %h", pk(qb[0]), {8'h10, 8'h80, 8'h90, 10'd0, 9'd0, 1'b1}); end
    endtask

    task automatic test_reset_mid();
        logic [46:0] got;
        logic [95:0] bytes;
        vsync_pulse();
        bytes = 96'h80109020_8455_0000_00000000;
        for (int i = 0; i < 6; i++) begin
            @(negedge PCLK);
            HREF = 1'b1;
            D    = bytes[95-8*i -: 8];
        end
        @(negedge PCLK);
        checks++;
        if ({y_a, x_a} !== {8'h20, 10'd1}) begin errors++; $display("FAIL rstmid_pre got %h exp %h", {y_a, x_a}, {8'h20, 10'd1}); end
        #2 rst_n = 1'b0;
        #1;
        got = {e_a, y_a, cb_a, cr_a, x_a, yp_a, fs_a, fdn_a, le_a};
        checks++;
        if (got !== 47'd0) begin errors++; $display("FAIL rstmid_async got %h exp 0", got); end
        HREF = 1'b0; D = 8'h00;
        @(negedge PCLK); rst_n = 1'b1;
        clear_logs();
        send_line(96'h80109020_84309440_00000000, 8);
        send_line(96'h80109020_00000000_00000000, 4);
        checks++;
        if (qa.size() != 0) begin errors++; $display("FAIL rstmid_quiet got %0d exp 0", qa.size()); end
        vsync_pulse();
        send_line(96'h80109020_00000000_00000000, 4);
        checks++;
        if (qa.size() != 2 || qa[0].fs !== 1'b1)
            begin errors++; $display("FAIL rstmid_resume got pix=%0d fs=%b exp 2/1", qa.size(), qa[0].fs); end
    endtask

    task automatic test_partial();
        vsync_pulse();
        clear_logs();
        send_line(96'h801090_000000_00000000_0000, 3);
        checks++;
        if (qa.size() != 1 || pk(qa[0]) !== {8'h10, 8'h80, 8'h90, 10'd0, 9'd0, 1'b1})
            begin errors++; $display("FAIL partial_px got n=%0d %h exp 1 %h", qa.size(), pk(qa[0]), {8'h10, 8'h80, 8'h90, 10'd0, 9'd0, 1'b1}); end
        checks++;
        if (le_a !== 1'b1) begin errors++; $display("FAIL partial_err got %b exp 1", le_a); end
        send_line(96'h80109020_00000000_00000000, 4);
        checks++;
        if (qa.size() != 3 || qa[1].yp !== 9'd1 || qa[1].x !== 10'd0)
            begin errors++; $display("FAIL partial_next got n=%0d y=%0d x=%0d exp 3/1/0", qa.size(), qa[1].yp, qa[1].x); end
        vsync_pulse();
        checks++;
        if (le_a !== 1'b0) begin errors++; $display("FAIL partial_clear got %b exp 0", le_a); end
    endtask

    task automatic test_overlong();
        vsync_pulse();
        clear_logs();
        send_line(96'h80109020_81119121_82129222, 12);
        checks++;
        if (qa.size() != 4) begin errors++; $display("FAIL overlong_count got %0d exp 4", qa.size()); end
        checks++;
        if (pk(qa[3]) !== {8'h21, 8'h81, 8'h91, 10'd3, 9'd0, 1'b0})
            begin errors++; $display("FAIL overlong_px3 got %h exp %h", pk(qa[3]), {8'h21, 8'h81, 8'h91, 10'd3, 9'd0, 1'b0}); end
        checks++;
        if (le_a !== 1'b1) begin errors++; $display("FAIL overlong_err got %b exp 1", le_a); end
    endtask

    task automatic test_extra_lines();
        vsync_pulse();
        clear_logs();
        for (int l = 0; l < 3; l++) send_line(96'h80109020_00000000_00000000, 4);
        checks++;
        if (qa.size() != 4) begin errors++; $display("FAIL vlines_count got %0d exp 4", qa.size()); end
        checks++;
        if (pk(qa[3]) !== {8'h20, 8'h80, 8'h90, 10'd1, 9'd1, 1'b0})
            begin errors++; $display("FAIL vlines_last got %h exp %h", pk(qa[3]), {8'h20, 8'h80, 8'h90, 10'd1, 9'd1, 1'b0}); end
        checks++;
        if (le_a !== 1'b0) begin errors++; $display("FAIL vlines_err got %b exp 0", le_a); end
    endtask

    task automatic test_cr_first();
        vsync_pulse();
        clear_logs();
        send_line(96'h90108020_00000000_00000000, 4);
        checks++;
        if (qc.size() != 2) begin errors++; $display("FAIL crfirst_count got %0d exp 2", qc.size()); end
        checks++;
        if (pk(qc[0]) !== {8'h10, 8'h80, 8'h90, 10'd0, 9'd0, 1'b1})
            begin errors++; $display("FAIL crfirst_px0 got %h exp %h", pk(qc[0]), {8'h10, 8'h80, 8'h90, 10'd0, 9'd0, 1'b1}); end
        checks++;
        if (pk(qc[1]) !== {8'h20, 8'h80, 8'h90, 10'd1, 9'd0, 1'b0})
            begin errors++; $display("FAIL crfirst_px1 got %h exp %h", pk(qc[1]), {8'h20, 8'h80, 8'h90, 10'd1, 9'd0, 1'b0}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skip();
        test_reset_mid();
        test_partial();
        test_overlong();
        test_extra_lines();
        test_cr_first();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
